// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NREQ requesters (IDLE/EXEC/RESP).
// Optional statistics counters are enabled by defining ALU_ARB_STATS_EN.
module alu_share_arbiter #(
  parameter int NREQ = 2,
  parameter int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic [NREQ-1:0]      req_valid_i,
  output logic [NREQ-1:0]      req_ready_o,
  input  logic [NREQ*32-1:0]   req_a_i,
  input  logic [NREQ*32-1:0]   req_b_i,
  input  logic [NREQ*5-1:0]    req_op_i,
  output logic [31:0]          alu_a_o,
  output logic [31:0]          alu_b_o,
  output logic [4:0]           alu_op_o,
  input  logic [31:0]          alu_result_i,
  input  logic                 alu_flag_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [ID_W-1:0]      rsp_id_o,
  output logic [31:0]          rsp_result_o,
  output logic                 rsp_flag_o,
  output logic                 busy_o
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [31:0]          ops_done_o,
  output logic [31:0]          stall_cycles_o
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  id_q;
  logic [31:0]      a_q, b_q, result_q;
  logic [4:0]       op_q;
  logic             flag_q;

  logic [31:0]      a_arr  [NREQ];
  logic [31:0]      b_arr  [NREQ];
  logic [4:0]       op_arr [NREQ];

  logic             grant_found;
  logic [ID_W-1:0]  grant_idx;
  logic             accept;
  logic             handshake;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign a_arr[gi]  = req_a_i[32*gi +: 32];
      assign b_arr[gi]  = req_b_i[32*gi +: 32];
      assign op_arr[gi] = req_op_i[5*gi +: 5];
    end
  endgenerate

  // First valid requester at or after the pointer, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      int cand;
      cand = int'(ptr_q) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!grant_found && req_valid_i[cand]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(cand);
      end
    end
  end

  assign accept    = (state_q == IDLE) && grant_found && !clear_i;
  assign handshake = (state_q == RESP) && rsp_ready_i && !clear_i;

  always_comb begin
    int nxt;
    nxt   = int'(grant_idx) + 1;
    ptr_d = (nxt >= NREQ) ? '0 : ID_W'(nxt);
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; clear_i overrides everything
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (handshake) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear_i) state_d = IDLE;
  end

  // Output logic
  always_comb begin
    req_ready_o = '0;
    if (accept) req_ready_o[grant_idx] = 1'b1;
    rsp_valid_o = (state_q == RESP);
    busy_o      = (state_q != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q    <= '0;
      id_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      flag_q   <= 1'b0;
    end else begin
      if (accept) begin
        ptr_q <= ptr_d;
        id_q  <= grant_idx;
        a_q   <= a_arr[grant_idx];
        b_q   <= b_arr[grant_idx];
        op_q  <= op_arr[grant_idx];
      end
      if (state_q == EXEC) begin
        result_q <= alu_result_i;
        flag_q   <= alu_flag_i;
      end
    end
  end

  assign alu_a_o      = a_q;
  assign alu_b_o      = b_q;
  assign alu_op_o     = op_q;
  assign rsp_id_o     = id_q;
  assign rsp_result_o = result_q;
  assign rsp_flag_o   = flag_q;

`ifdef ALU_ARB_STATS_EN
  logic [31:0] ops_done_q, stall_cycles_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ops_done_q     <= '0;
      stall_cycles_q <= '0;
    end else begin
      if (handshake)                  ops_done_q     <= ops_done_q + 32'd1;
      if (rsp_valid_o && !rsp_ready_i) stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  assign ops_done_o     = ops_done_q;
  assign stall_cycles_o = stall_cycles_q;
`endif

endmodule
